// File: rtl/apb_gpio_slave_if.sv
// APB completer-side bus bundle for the GPIO slot: request from the bridge, response back.
// Latency: none, wires only.
// Backpressure: carried by PREADY from the completer to the requester.
interface apb_gpio_slave_if #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int STRB_WIDTH    = 4
);
   logic                     PSEL;
   logic                     PENABLE;
   logic                     PWRITE;
   logic [ADDRESS_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0]    PWDATA;
   logic [STRB_WIDTH-1:0]    PSTRB;
   logic [DATA_WIDTH-1:0]    PRDATA;
   logic                     PREADY;
   logic                     PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB GPIO completer: output/direction registers, synchronized inputs, edge interrupts.
// Latency: 2+WAIT_STATES cycles per transfer; pin edge -> IRQ_STATUS after 3 edges, irq 1 later.
// Backpressure: PREADY held low for WAIT_STATES ACCESS cycles, then completes unconditionally.
module apb_gpio_slave #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4,
   parameter int STRB_WIDTH    = 4,
   parameter int WAIT_STATES   = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb_gpio_slave_if.slave       apb,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   localparam logic [2:0] IDX_DATA_OUT   = 3'd0;
   localparam logic [2:0] IDX_DIR        = 3'd1;
   localparam logic [2:0] IDX_DATA_IN    = 3'd2;
   localparam logic [2:0] IDX_IRQ_EN     = 3'd3;
   localparam logic [2:0] IDX_IRQ_STATUS = 3'd4;
   localparam logic [2:0] IDX_IRQ_POL    = 3'd5;

   // Register state
   logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
   logic [DATA_WIDTH-1:0] dir_q,        dir_d;
   logic [DATA_WIDTH-1:0] irq_en_q,     irq_en_d;
   logic [DATA_WIDTH-1:0] irq_status_q, irq_status_d;
   logic [DATA_WIDTH-1:0] irq_pol_q,    irq_pol_d;
   // Pin synchronizer; sync3 is the previous synchronized value for edge detection
   logic [DATA_WIDTH-1:0] sync1_q,      sync1_d;
   logic [DATA_WIDTH-1:0] sync2_q,      sync2_d;
   logic [DATA_WIDTH-1:0] sync3_q,      sync3_d;
   // Wait-state counter and registered interrupt
   logic [3:0]            cnt_q,        cnt_d;
   logic                  irq_q,        irq_d;

   // Bus decode
   logic [2:0]            idx;
   logic                  setup_ph;
   logic                  access_ph;
   logic                  pready;
   logic                  err;
   logic                  wr_commit;
   logic [DATA_WIDTH-1:0] bmask;
   logic [DATA_WIDTH-1:0] w1c;
   logic [DATA_WIDTH-1:0] edge_set;
   logic [DATA_WIDTH-1:0] rd_val;

   // PADDR[3] selects the slot in the bridge and carries no meaning here
   logic unused_addr;
   assign unused_addr = ^apb.PADDR[ADDRESS_WIDTH-1:3];

   assign idx       = apb.PADDR[2:0];
   assign setup_ph  = apb.PSEL & ~apb.PENABLE;
   assign access_ph = apb.PSEL &  apb.PENABLE;
   // Gated by reset so a requester still driving ACCESS during reset sees no completion
   assign pready    = PRESETn & access_ph & (cnt_q == 4'd0);
   assign err       = (idx == 3'd6) | (idx == 3'd7) | (apb.PWRITE & (idx == IDX_DATA_IN));
   assign wr_commit = pready & apb.PWRITE & ~err;

   // Merge new write data into the old value, byte lane by byte lane
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_val,
      input logic [DATA_WIDTH-1:0] new_val,
      input logic [DATA_WIDTH-1:0] mask
   );
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // Expand byte strobes into a bit mask
   always_comb begin
      bmask = '0;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         bmask[b*8 +: 8] = {8{apb.PSTRB[b]}};
      end
   end

   // Edge events selected per pin by IRQ_POL (1 = rising, 0 = falling)
   always_comb begin
      edge_set = ( sync2_q & ~sync3_q &  irq_pol_q)
               | (~sync2_q &  sync3_q & ~irq_pol_q);
      w1c      = (wr_commit && (idx == IDX_IRQ_STATUS)) ? (apb.PWDATA & bmask) : '0;
   end

   // Read data mux; response fields are zero outside the completing cycle
   always_comb begin
      rd_val = '0;
      case (idx)
         IDX_DATA_OUT:   rd_val = data_out_q;
         IDX_DIR:        rd_val = dir_q;
         IDX_DATA_IN:    rd_val = sync2_q;
         IDX_IRQ_EN:     rd_val = irq_en_q;
         IDX_IRQ_STATUS: rd_val = irq_status_q;
         IDX_IRQ_POL:    rd_val = irq_pol_q;
         default:        rd_val = '0;
      endcase
   end

   assign apb.PREADY  = pready;
   assign apb.PRDATA  = pready ? rd_val : '0;
   assign apb.PSLVERR = pready & err;

   // Next-state: wait counter, register writes, synchronizer, status, irq
   always_comb begin
      cnt_d        = cnt_q;
      data_out_d   = data_out_q;
      dir_d        = dir_q;
      irq_en_d     = irq_en_q;
      irq_pol_d    = irq_pol_q;
      sync1_d      = gpio_in;
      sync2_d      = sync1_q;
      sync3_d      = sync2_q;
      irq_d        = |(irq_status_q & irq_en_q);

      // Abandoned transfers (PSEL low) leave the counter cleared; SETUP reloads it
      if (!apb.PSEL) begin
         cnt_d = 4'd0;
      end else if (setup_ph) begin
         cnt_d = WS;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end

      if (wr_commit) begin
         case (idx)
            IDX_DATA_OUT: data_out_d = merge_bytes(data_out_q, apb.PWDATA, bmask);
            IDX_DIR:      dir_d      = merge_bytes(dir_q,      apb.PWDATA, bmask);
            IDX_IRQ_EN:   irq_en_d   = merge_bytes(irq_en_q,   apb.PWDATA, bmask);
            IDX_IRQ_POL:  irq_pol_d  = merge_bytes(irq_pol_q,  apb.PWDATA, bmask);
            default:      ;
         endcase
      end

      // A new edge in the same cycle as a clear keeps the bit set
      irq_status_d = (irq_status_q & ~w1c) | edge_set;
   end

   // State registers, cleared asynchronously
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q        <= '0;
         data_out_q   <= '0;
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_status_q <= '0;
         irq_pol_q    <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         sync3_q      <= '0;
         irq_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         dir_q        <= dir_d;
         irq_en_q     <= irq_en_d;
         irq_status_q <= irq_status_d;
         irq_pol_q    <= irq_pol_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         irq_q        <= irq_d;
      end
   end

   assign gpio_out = data_out_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
// Latency: transfers checked for their exact wait-state count.
// Backpressure: the bench waits on PREADY with a bounded cycle budget.
module tb_apb_gpio_slave;

   logic        PCLK;
   logic        PRESETn;
   bit          sel;        // 0 -> dut0 (1 wait state), 1 -> dut3 (3 wait states)
   logic        psel, penable, pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out0, gpio_oe0, gpio_out3, gpio_oe3;
   logic        irq0, irq3;
   logic [31:0] prdata;
   logic        pready, pslverr;

   int checks   = 0;
   int failures = 0;

   apb_gpio_slave_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus0 ();
   apb_gpio_slave_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus3 ();

   assign bus0.PSEL    = psel & ~sel;
   assign bus0.PENABLE = penable;
   assign bus0.PWRITE  = pwrite;
   assign bus0.PADDR   = paddr;
   assign bus0.PWDATA  = pwdata;
   assign bus0.PSTRB   = pstrb;
   assign bus3.PSEL    = psel & sel;
   assign bus3.PENABLE = penable;
   assign bus3.PWRITE  = pwrite;
   assign bus3.PADDR   = paddr;
   assign bus3.PWDATA  = pwdata;
   assign bus3.PSTRB   = pstrb;

   assign prdata  = sel ? bus3.PRDATA  : bus0.PRDATA;
   assign pready  = sel ? bus3.PREADY  : bus0.PREADY;
   assign pslverr = sel ? bus3.PSLVERR : bus0.PSLVERR;

   apb_gpio_slave #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .STRB_WIDTH(4), .WAIT_STATES(1)) dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0.slave),
      .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0)
   );

   apb_gpio_slave #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .STRB_WIDTH(4), .WAIT_STATES(3)) dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus3.slave),
      .gpio_in(gpio_in), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3), .irq(irq3)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // One APB transfer; called #1 after a posedge, returns #1 after the commit edge
   task automatic apb_xfer(input bit s, input bit wr, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] rdata, output logic err, output int waits);
      sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = wdata; pstrb = strb;
      @(posedge PCLK); #1;
      penable = 1'b1;
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (pready === 1'b1) break;
         waits++;
         @(posedge PCLK); #1;
      end
      rdata = prdata;
      err   = pslverr;
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; sel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
      paddr = 4'd0; pwdata = '0; pstrb = 4'hF; gpio_in = '0;
      repeat (3) @(negedge PCLK);
      checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready); end
      checks++; if (gpio_out0 !== 32'h0) begin failures++; $display("FAIL reset_gpio_out got=%h exp=0", gpio_out0); end
      checks++; if (gpio_oe0 !== 32'h0) begin failures++; $display("FAIL reset_gpio_oe got=%h exp=0", gpio_oe0); end
      checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq0); end
      checks++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin failures++; $display("FAIL reset_resp prdata=%h pslverr=%b exp=0/0", prdata, pslverr); end
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
   endtask

   task automatic test_read_all();
      logic [31:0] rd; logic er; int w; logic [3:0] a;
      for (int i = 0; i < 8; i++) begin
         a = {i[0], i[2:0]};   // PADDR[3] toggled to show it is ignored
         apb_xfer(1'b0, 1'b0, a, 32'hFFFF_FFFF, 4'hF, rd, er, w);
         checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_all_data idx=%0d got=%h exp=0", i, rd); end
         checks++; if (er !== (i >= 6)) begin failures++; $display("FAIL read_all_err idx=%0d got=%b exp=%b", i, er, (i >= 6)); end
         checks++; if (w != 1) begin failures++; $display("FAIL read_all_waits idx=%0d got=%0d exp=1", i, w); end
      end
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic er; int w;
      apb_xfer(1'b0, 1'b1, 4'd1, 32'hA5A5_A5A5, 4'b0101, rd, er, w);
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL strobe_dir_err got=%b exp=0", er); end
      apb_xfer(1'b0, 1'b0, 4'd1, 32'h0, 4'h0, rd, er, w);
      checks++; if (rd !== 32'h00A5_00A5) begin failures++; $display("FAIL strobe_dir_read got=%h exp=00a500a5", rd); end
      checks++; if (gpio_oe0 !== 32'h00A5_00A5) begin failures++; $display("FAIL strobe_gpio_oe got=%h exp=00a500a5", gpio_oe0); end
      apb_xfer(1'b0, 1'b1, 4'd0, 32'h1234_5678, 4'hF, rd, er, w);
      apb_xfer(1'b0, 1'b1, 4'd0, 32'hABCD_EF01, 4'b1000, rd, er, w);
      checks++; if (gpio_out0 !== 32'hAB34_5678) begin failures++; $display("FAIL strobe_gpio_out got=%h exp=ab345678", gpio_out0); end
   endtask

   task automatic test_irq_rise();
      logic [31:0] rd; logic er; int w;
      apb_xfer(1'b0, 1'b1, 4'd5, 32'h1, 4'hF, rd, er, w);   // IRQ_POL[0] = rising
      apb_xfer(1'b0, 1'b1, 4'd3, 32'h1, 4'hF, rd, er, w);   // IRQ_EN[0]
      gpio_in = 32'h0000_0001;
      repeat (3) @(negedge PCLK);                           // after 2 edges
      checks++; if (dut0.irq_status_q[0] !== 1'b0) begin failures++; $display("FAIL irq_status_early got=1 exp=0"); end
      @(negedge PCLK);                                      // after 3 edges
      checks++; if (dut0.irq_status_q[0] !== 1'b1) begin failures++; $display("FAIL irq_status_set got=%b exp=1", dut0.irq_status_q[0]); end
      checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq0); end
      @(negedge PCLK);
      checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq0); end
      @(posedge PCLK); #1;
      apb_xfer(1'b0, 1'b0, 4'd4, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h1) begin failures++; $display("FAIL irq_status_read got=%h exp=1", rd); end
      apb_xfer(1'b0, 1'b1, 4'd4, 32'h1, 4'hF, rd, er, w);   // W1C bit 0
      apb_xfer(1'b0, 1'b0, 4'd4, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL irq_w1c_read got=%h exp=0", rd); end
      checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_w1c_irq got=%b exp=0", irq0); end
   endtask

   task automatic test_err_write();
      logic [31:0] rd; logic er; int w;
      apb_xfer(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, rd, er, w);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_write_pslverr got=%b exp=1", er); end
      checks++; if (w != 1) begin failures++; $display("FAIL err_write_waits got=%0d exp=1", w); end
      apb_xfer(1'b0, 1'b0, 4'd2, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h1 || er !== 1'b0) begin failures++; $display("FAIL err_datain_read got=%h/%b exp=00000001/0", rd, er); end
      apb_xfer(1'b0, 1'b1, 4'd7, 32'hFFFF_FFFF, 4'hF, rd, er, w);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_write_rsvd got=%b exp=1", er); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int w;
      apb_xfer(1'b0, 1'b1, 4'd0, 32'hCAFE_F00D, 4'hF, rd, er, w);
      apb_xfer(1'b0, 1'b0, 4'd0, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_read_data got=%h exp=cafef00d", rd); end
      checks++; if (w != 1) begin failures++; $display("FAIL b2b_waits got=%0d exp=1", w); end
      apb_xfer(1'b0, 1'b0, 4'd1, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h00A5_00A5 || w != 1) begin failures++; $display("FAIL b2b_read_dir got=%h/%0d exp=00a500a5/1", rd, w); end
      checks++; if (gpio_out0 !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_gpio_out got=%h exp=cafef00d", gpio_out0); end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] rd; logic er; int w;
      gpio_in = 32'h0000_0021;          // rising on bit 5 with falling polarity: no event
      repeat (5) @(posedge PCLK); #1;
      apb_xfer(1'b0, 1'b0, 4'd4, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_pre_status got=%h exp=0", rd); end
      gpio_in = 32'h0000_0001;          // falling edge on bit 5 lands on the W1C commit edge
      apb_xfer(1'b0, 1'b1, 4'd4, 32'h20, 4'hF, rd, er, w);
      apb_xfer(1'b0, 1'b0, 4'd4, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h20) begin failures++; $display("FAIL w1c_collision_status got=%h exp=00000020", rd); end
      apb_xfer(1'b0, 1'b1, 4'd4, 32'h20, 4'hF, rd, er, w);
      apb_xfer(1'b0, 1'b0, 4'd4, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_clear_status got=%h exp=0", rd); end
   endtask

   task automatic test_abandon();
      logic [31:0] rd; logic er; int w;
      apb_xfer(1'b1, 1'b1, 4'd0, 32'h1111_1111, 4'hF, rd, er, w);
      checks++; if (w != 3) begin failures++; $display("FAIL abandon_ws3_waits got=%0d exp=3", w); end
      sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 4'd0; pwdata = 32'h2222_2222; pstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      checks++; if (pready !== 1'b0) begin failures++; $display("FAIL abandon_pready got=%b exp=0", pready); end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (4) @(posedge PCLK); #1;
      checks++; if (gpio_out3 !== 32'h1111_1111) begin failures++; $display("FAIL abandon_gpio_out got=%h exp=11111111", gpio_out3); end
      apb_xfer(1'b1, 1'b0, 4'd0, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h1111_1111 || w != 3) begin failures++; $display("FAIL abandon_read got=%h/%0d exp=11111111/3", rd, w); end
   endtask

   task automatic test_reset_midwrite();
      logic [31:0] rd; logic er; int w;
      sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 4'd1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK); #1;
      PRESETn = 1'b0;
      #1;
      checks++; if (gpio_oe0 !== 32'h0 || gpio_out0 !== 32'h0) begin failures++; $display("FAIL midreset_outputs oe=%h out=%h exp=0/0", gpio_oe0, gpio_out0); end
      checks++; if (pready !== 1'b0) begin failures++; $display("FAIL midreset_pready got=%b exp=0", pready); end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      apb_xfer(1'b0, 1'b0, 4'd1, 32'h0, 4'hF, rd, er, w);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midreset_dir got=%h exp=0", rd); end
   endtask

   initial begin
      test_reset();
      test_read_all();
      test_strobe();
      test_irq_rise();
      test_err_write();
      test_back_to_back();
      test_w1c_collision();
      test_abandon();
      test_reset_midwrite();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_gpio_slave.md
# apb_gpio_slave

APB completer (slave) implementing a 32-bit GPIO peripheral with programmable wait states, byte-strobed writes, error response and edge-triggered interrupts. It sits on the slave side of the APB bus, on PSEL bit 1 of the team's APB bridge (the bridge's slave-select bit 1 is the GPIO slot). It responds to the bridge's SETUP/ACCESS sequence with PREADY, PRDATA and PSLVERR.

## Interface
- DATA_WIDTH, 32, data bus and GPIO pin count
- ADDRESS_WIDTH, 4, PADDR width; PADDR[2:0] is the word register index; PADDR[3] is ignored (consumed by the bridge for slave select)
- STRB_WIDTH, 4, one strobe bit per byte
- WAIT_STATES, 1, extra ACCESS cycles with PREADY low before completion (0..15)

- PCLK  in  1  APB clock
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  slave select from the bridge
- PENABLE  in  1  ACCESS phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDRESS_WIDTH  register address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  STRB_WIDTH  write byte enables
- PRDATA  out  DATA_WIDTH  read data, valid only when PREADY=1
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response, valid only when PREADY=1
- gpio_in  in  DATA_WIDTH  asynchronous pin inputs
- gpio_out  out  DATA_WIDTH  pin output values (DATA_OUT register)
- gpio_oe  out  DATA_WIDTH  pin output enables (DIR register)
- irq  out  1  level interrupt, registered

## Operation
- Register map (index = PADDR[2:0]):
  - 0 DATA_OUT: RW
  - 1 DIR: RW, 1 = output
  - 2 DATA_IN: RO, synchronized pins
  - 3 IRQ_EN: RW
  - 4 IRQ_STATUS: write-1-to-clear
  - 5 IRQ_POL: RW, 1 = rising edge, 0 = falling edge
  - 6, 7: reserved
- Writes update only the bytes whose PSTRB bit is set. PSTRB is ignored on reads.
- Error cases (PSLVERR=1 on the completing cycle, no register change):
  - any access to index 6 or 7
  - a write to index 2
  - Reads of reserved indices return PRDATA=0.
- gpio_in passes through a 2-flop synchronizer. DATA_IN returns the second flop. A third flop holds the previous synchronized value for edge detection.
- IRQ_STATUS[i] sets on the edge of sync_in[i] selected by IRQ_POL[i], regardless of IRQ_EN. A W1C of bit i clears it.
- irq is registered as |(IRQ_STATUS & IRQ_EN).

## Timing
- Reset: all registers, PRDATA, PREADY, PSLVERR, gpio_out, gpio_oe, irq, synchronizer flops and wait counter = 0.
- SETUP cycle (PSEL=1, PENABLE=0): wait counter loads WAIT_STATES.
- ACCESS cycles (PSEL=1, PENABLE=1):
  - While the counter is nonzero: PREADY=0 and the counter decrements.
  - When the counter is 0: PREADY=1 (combinational from the counter and PSEL/PENABLE).
  - A transfer therefore takes 2+WAIT_STATES cycles.
- PRDATA and PSLVERR are driven from the decoded address in the PREADY=1 cycle. Otherwise both are 0.
- Write commit occurs at the PCLK edge ending the PREADY=1 cycle. Exactly one commit per transfer.
- PSEL dropping mid-ACCESS: transfer abandoned, counter cleared, no commit.
- Back-to-back transfers (SETUP immediately after completion) are supported. The counter reloads on each SETUP.
- Edge-to-status latency: a pin edge sets IRQ_STATUS 3 PCLK edges later; irq rises 1 cycle after that.
- Same-cycle status set and W1C on the same bit: set wins.
- DATA_OUT, DIR and IRQ_EN writes take effect on gpio_out/gpio_oe/irq logic the cycle after commit.
- Reset asserted mid-transfer: all state returns to reset values immediately. The interrupted write is not committed.

## Test plan
- Reset, then read every index with WAIT_STATES=1:
  - indices 0-5 -> PRDATA=0, PSLVERR=0, PREADY low for exactly 1 ACCESS cycle
  - indices 6 and 7 -> PSLVERR=1
- Write 0xA5A5_A5A5 to DIR with PSTRB=4'b0101, then read back -> 0x00A5_00A5; gpio_oe matches.
- Drive gpio_in=0x0000_0001 with IRQ_POL[0]=1 and IRQ_EN[0]=1:
  - IRQ_STATUS[0] is set 3 cycles after the edge; irq=1 one cycle later.
  - Write 0x1 to index 4 -> status and irq clear.
- Write 0xFFFF_FFFF to index 2 -> PSLVERR=1 with PREADY=1. A subsequent DATA_IN read returns the pin value, unchanged by the write.
- Write to DATA_OUT, then deassert PSEL after SETUP plus 1 ACCESS cycle with WAIT_STATES=3 -> no commit; DATA_OUT keeps its old value.
- Falling edge on gpio_in[5] (IRQ_POL[5]=0) in the same cycle as a W1C of bit 5 -> IRQ_STATUS[5] stays 1.
